// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and fetch FSM encodings
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        ERR  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC selection and PC write enable
// Only the PC top nibble and the IR jump index are needed for the jump target.
module pc_next_mux #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_pc_hi,
    input  logic [25:0]      i_ir_index,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_pc_src,
    input  logic             i_enable_j,
    input  logic             i_pc_write,
    input  logic             i_branch,
    input  logic             i_zero,
    output logic [WIDTH-1:0] o_next_pc,
    output logic             o_pc_en
);

    logic [WIDTH-1:0] w_jump_target;

    assign w_jump_target = {i_pc_hi, {(WIDTH-32){1'b0}}, i_ir_index, 2'b00};

    // enable_j is active-low: a low level overrides the pc_src choice
    always_comb begin
        o_next_pc = i_alu_result;
        if (!i_enable_j) begin
            o_next_pc = w_jump_target;
        end else if (i_pc_src) begin
            o_next_pc = i_alu_out;
        end
    end

    assign o_pc_en = i_pc_write | (i_branch & i_zero);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle MIPS instruction fetch: PC/IR registers and memory handshake
// Fetch FSM runs independently of PC updates; the request address is latched in REQ.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000,
    parameter int              TIMEOUT  = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fetch_start,
    input  logic             i_pc_write,
    input  logic             i_branch,
    input  logic             i_zero,
    input  logic             i_pc_src,
    input  logic             i_enable_j,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [WIDTH-1:0] i_mem_rdata,
    input  logic             i_mem_ready,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic             o_mem_rd,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_ir,
    output logic [5:0]       o_op,
    output logic [5:0]       o_funct,
    output logic             o_ir_valid,
    output logic             o_busy,
    output logic             o_fetch_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_addr;
    logic [7:0]       r_cnt;
    logic             r_mem_rd;
    logic             r_busy;
    logic             r_ir_valid;
    logic             r_fetch_err;

    logic [WIDTH-1:0] w_next_pc;
    logic             w_pc_en;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_pc_next_mux (
        .i_pc_hi      (r_pc[WIDTH-1:WIDTH-4]),
        .i_ir_index   (r_ir[25:0]),
        .i_alu_result (i_alu_result),
        .i_alu_out    (i_alu_out),
        .i_pc_src     (i_pc_src),
        .i_enable_j   (i_enable_j),
        .i_pc_write   (i_pc_write),
        .i_branch     (i_branch),
        .i_zero       (i_zero),
        .o_next_pc    (w_next_pc),
        .o_pc_en      (w_pc_en)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_addr      <= RESET_PC;
            r_cnt       <= '0;
            r_mem_rd    <= 1'b0;
            r_busy      <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            if (w_pc_en) begin
                r_pc <= w_next_pc;
            end
            case (r_state)
                IDLE: begin
                    if (i_fetch_start) begin
                        r_state  <= REQ;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    r_addr <= r_pc;
                    r_cnt  <= '0;
                    if (i_mem_ready) begin
                        r_ir       <= i_mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_mem_rd   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_ready) begin
                        r_ir       <= i_mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_mem_rd   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_mem_rd    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // REQ drives the live PC; WAIT holds the address latched at the end of REQ
    assign o_mem_addr  = (r_state == REQ) ? r_pc : r_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_op        = r_ir[31:26];
    assign o_funct     = r_ir[5:0];
    assign o_ir_valid  = r_ir_valid;
    assign o_busy      = r_busy;
    assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst, fetch_start, pc_write, branch, zero, pc_src, enable_j, mem_ready;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic [31:0] mem_addr, pc, ir;
    logic        mem_rd, ir_valid, busy, fetch_err;
    logic [5:0]  op, funct;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_start(fetch_start), .i_pc_write(pc_write),
        .i_branch(branch), .i_zero(zero), .i_pc_src(pc_src), .i_enable_j(enable_j),
        .i_alu_result(alu_result), .i_alu_out(alu_out), .i_mem_rdata(mem_rdata),
        .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_pc(pc),
        .o_ir(ir), .o_op(op), .o_funct(funct), .o_ir_valid(ir_valid), .o_busy(busy),
        .o_fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw, br, zr, src, ej;
        logic [31:0] alu_res, alu_o, exp_pc;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        // pc_write, branch, zero, pc_src, enable_j, alu_result, alu_out, expected pc
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0,          32'h0040_0004};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0,          32'h0040_0004};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,          32'h0040_0020, 32'h0040_0020};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0008, 32'h0,          32'h0040_0008};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0040_000C};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          32'hDEAD_BEEF, 32'h0040_000C};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,          32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0,          32'hF040_000C};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h5,          32'h0000_0000};

        rst = 1'b1; fetch_start = 1'b0; pc_write = 1'b0; branch = 1'b0; zero = 1'b0;
        pc_src = 1'b0; enable_j = 1'b1; mem_ready = 1'b0;
        alu_result = '0; alu_out = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_pc", pc, RST_PC);
        chk("reset_ir", ir, 32'h0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ir_valid", ir_valid, 0);
        chk("reset_err", fetch_err, 0);

        // zero-wait fetch
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("req_mem_rd", mem_rd, 1);
        chk("req_mem_addr", mem_addr, RST_PC);
        chk("req_busy", busy, 1);
        chk("req_ir_valid", ir_valid, 0);
        tick();
        chk("fast_ir", ir, 32'h2008_0005);
        chk("fast_op", op, OP_ADDI);
        chk("fast_ir_valid", ir_valid, 1);
        chk("fast_mem_rd_drop", mem_rd, 0);
        chk("fast_pc", pc, RST_PC);
        tick();
        chk("fast_ir_valid_pulse", ir_valid, 0);

        // ready arrives in the fourth request cycle
        mem_ready = 1'b0; mem_rdata = 32'h0810_0003; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("slow_mem_rd_%0d", i), mem_rd, 1);
            chk($sformatf("slow_busy_%0d", i), busy, 1);
            if (i == 2) chk("slow_ir_held", ir, 32'h2008_0005);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        chk("slow_ir", ir, 32'h0810_0003);
        chk("slow_op", op, OP_J);
        chk("slow_ir_valid", ir_valid, 1);
        chk("slow_mem_rd_drop", mem_rd, 0);
        chk("slow_err", fetch_err, 0);

        // PC update table (ir holds a jump with index 26'h010_0003)
        for (int i = 0; i < 9; i++) begin
            pc_write = vecs[i].pw; branch = vecs[i].br; zero = vecs[i].zr;
            pc_src = vecs[i].src; enable_j = vecs[i].ej;
            alu_result = vecs[i].alu_res; alu_out = vecs[i].alu_o;
            tick();
            pc_write = 1'b0; branch = 1'b0; zero = 1'b0; pc_src = 1'b0; enable_j = 1'b1;
            chk($sformatf("pc_vec_%0d", i), pc, vecs[i].exp_pc);
        end

        // PC moves during an in-flight fetch; address stays at the old PC
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("mid_req_addr", mem_addr, 32'h0);
        pc_write = 1'b1; alu_result = 32'h0040_0100;
        tick();
        pc_write = 1'b0;
        chk("mid_pc_new", pc, 32'h0040_0100);
        chk("mid_wait_addr", mem_addr, 32'h0);
        tick();
        chk("mid_wait_addr2", mem_addr, 32'h0);
        chk("mid_wait_rd", mem_rd, 1);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0020;
        tick();
        mem_ready = 1'b0;
        chk("mid_ir", ir, 32'h0000_0020);
        chk("mid_funct", funct, FN_ADD);
        chk("mid_op", op, OP_RTYPE);
        chk("mid_pc_kept", pc, 32'h0040_0100);

        // reset during WAIT
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("rstw_mem_rd", mem_rd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_mem_rd_clr", mem_rd, 0);
        chk("rstw_ir_clr", ir, 32'h0);
        chk("rstw_busy_clr", busy, 0);
        chk("rstw_pc", pc, RST_PC);

        // timeout: REQ plus 15 WAIT cycles, then sticky error
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (mem_rd && n < 40) begin
            n++;
            tick();
        end
        chk("to_rd_cycles", n, 16);
        chk("to_err", fetch_err, 1);
        chk("to_mem_rd", mem_rd, 0);
        chk("to_busy", busy, 0);
        fetch_start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        fetch_start = 1'b0; mem_ready = 1'b0;
        chk("err_ignore_rd", mem_rd, 0);
        chk("err_ignore_ir", ir, 32'h0);
        chk("err_sticky", fetch_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_rst_clr", fetch_err, 0);
        chk("err_rst_pc", pc, RST_PC);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("err_rst_refetch", mem_rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the multicycle MIPS datapath. It sits directly upstream of the FSM control unit and owns the PC and instruction registers. It fetches the word at PC from instruction memory over a ready/valid handshake and presents Op/Funct to the control unit. It applies the control unit's PC-update strobes (PC increment, branch, jump).

Parameters:
WIDTH, 32, datapath/address width
RESET_PC, 32'h0040_0000, PC value after reset
TIMEOUT, 15, max cycles to wait for mem_ready before flagging an error (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
fetch_start  in  1  pulse from control unit (IF state, IR_Write) requesting a fetch at current PC
pc_write  in  1  unconditional PC update strobe
branch  in  1  conditional PC update (beq)
zero  in  1  ALU zero flag
pc_src  in  1  0: next PC = alu_result, 1: next PC = alu_out
enable_j  in  1  active-low jump select; 0 forces jump target
alu_result  in  WIDTH  combinational ALU output
alu_out  in  WIDTH  registered ALU output
mem_rdata  in  WIDTH  instruction memory read data
mem_ready  in  1  memory read data valid this cycle
mem_addr  out  WIDTH  fetch address (equals PC while mem_rd)
mem_rd  out  1  memory read request
pc  out  WIDTH  current PC
ir  out  WIDTH  instruction register
op  out  6  ir[31:26]
funct  out  6  ir[5:0]
ir_valid  out  1  one-cycle pulse when ir is newly loaded
busy  out  1  fetch in progress (control unit must hold in IF)
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, ir=0, mem_rd=0, ir_valid=0, busy=0, fetch_err=0, state=IDLE, wait counter=0. Reset wins over every other input, including mid-fetch.
- FSM states: IDLE, REQ, WAIT, ERR.
  - IDLE: fetch_start=1 -> REQ.
  - REQ: mem_rd=1, mem_addr=pc, busy=1, counter cleared. If mem_ready=1 in this cycle: load ir, pulse ir_valid next cycle, go to IDLE. Otherwise go to WAIT.
  - WAIT: mem_rd=1, busy=1, counter++. mem_ready=1 -> load ir, ir_valid pulse, go to IDLE. Counter reaching TIMEOUT without ready -> set fetch_err, go to ERR.
  - ERR: mem_rd=0, busy=0. Leaves only on rst.
- Latency: with mem_ready combinationally high in REQ, ir is updated at the edge ending REQ. ir_valid is high in the following cycle. Minimum 2 cycles from fetch_start to ir_valid.
- fetch_start while busy or in ERR: ignored, no queuing.
- PC update (independent of the fetch FSM):
  - pc_en = pc_write | (branch & zero).
  - next_pc = jump target {pc[31:28], ir[25:0], 2'b00} when enable_j=0; else alu_out when pc_src=1; else alu_result.
  - When pc_en=1, pc <= next_pc at the clock edge.
- PC update while busy: allowed. mem_addr is captured into an internal address register in REQ, so the in-flight fetch completes at the old address.
- PC wraps naturally modulo 2^WIDTH. Alignment is not checked.
- op and funct are combinational slices of ir.

Decomposition:
- Shared package mips_pkg: opcode/funct constants (OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_ADDI=6'h08, OP_ORI=6'h0D, FN_ADD=6'h20) and fetch state encodings (IDLE=2'b00, REQ=2'b01, WAIT=2'b10, ERR=2'b11).
- Sub-module pc_next_mux: combinational selection of next_pc and pc_en.
- The FSM, counter and registers stay in fetch_unit.

Test Plan:
- Reset then fetch_start with mem_ready tied high, mem_rdata=32'h2008_0005 -> pc=32'h0040_0000, mem_addr=32'h0040_0000, ir=32'h2008_0005, op=6'h08, ir_valid pulses exactly 1 cycle, 2 cycles after fetch_start.
- mem_ready delayed 3 cycles -> mem_rd and busy held high 4 cycles, ir loads on the ready edge, fetch_err=0.
- mem_ready never asserted, TIMEOUT=15 -> fetch_err set after 15 WAIT cycles, mem_rd drops, later fetch_start ignored; rst=1 clears to IDLE with pc=RESET_PC.
- pc_write=1, pc_src=0, alu_result=32'h0040_0004 -> pc=32'h0040_0004 next cycle. Then branch=1, zero=0 -> pc unchanged. Then branch=1, zero=1, pc_src=1, alu_out=32'h0040_0020 -> pc=32'h0040_0020.
- ir=32'h0810_0003, enable_j=0, pc_write=1, pc=32'h0040_0008 -> pc=32'h0040_000C.
- pc_write asserted during WAIT -> mem_addr keeps the old PC until ready, pc takes the new value. rst asserted in WAIT -> mem_rd=0 and ir=0 on the next cycle.
